// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage (pipe_skid_reg).
// State codes are the pair (main_valid, skid_valid).
package pipe_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] FULL  = 2'b10;
  localparam logic [1:0] SKID  = 2'b11;

  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_FULL  = FULL,
    ST_SKID  = SKID
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// "slave" is the view of the stage itself, "master" the view of the
// surrounding logic (upstream producer plus downstream consumer).
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating enable counter used for stall statistics.
// Only compiled when PIPE_SKID_STATS_EN is defined, since nothing else uses it.
`ifdef PIPE_SKID_STATS_EN
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_r;

  // Count enabled cycles, sticking at all-ones; cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= {W{1'b0}};
    end else if (en_i && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule
`endif

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake, two-entry skid buffer
// (main + skid register) and a synchronous flush that inserts a bubble.
// Optional stall statistics counter enabled by the macro PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] NOP_VALUE   = {WIDTH{1'b0}}
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  pipe_skid_reg_if.slave         bus
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  pipe_state_e      state_r;
  logic             in_ready_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             in_fire_s;
  logic             out_fire_s;

  // in_ready is its own flop (always equal to !skid_valid) so that no
  // input can reach it combinationally.
  assign in_fire_s  = bus.in_valid_i & in_ready_r;
  assign out_fire_s = state_r[1] & bus.out_ready_i;

  // Stage state machine: flush wins, then the per-state handshake moves.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      main_data_r <= RESET_VALUE;
      skid_data_r <= RESET_VALUE;
    end else if (flush_i) begin
      // Anything accepted this cycle is dropped along with held entries.
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      main_data_r <= NOP_VALUE;
      skid_data_r <= NOP_VALUE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_r     <= ST_FULL;
            main_data_r <= bus.in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_data_r <= bus.in_data_i;
          end else if (in_fire_s) begin
            // Downstream stalled: park the new word behind the main entry.
            state_r     <= ST_SKID;
            in_ready_r  <= 1'b0;
            skid_data_r <= bus.in_data_i;
          end else if (out_fire_s) begin
            state_r <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire_s) begin
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b1;
            main_data_r <= skid_data_r;
          end
        end
        default: begin
          state_r    <= ST_EMPTY;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = state_r[1];
  assign bus.out_data_o  = main_data_r;

`ifdef PIPE_SKID_STATS_EN
  logic stall_s;

  assign stall_s = state_r[1] & ~bus.out_ready_i;

  pipe_sat_cnt #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_s),
    .cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg. The reference is a FIFO queue of
// accepted words with capacity two; outputs are checked against it every cycle.
module tb_pipe_skid_reg;

  localparam logic [31:0] RST_V = 32'hC0DE_0001;
  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic clk_i;
  logic rst_i;
  logic flush_i;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_cnt;
`endif

  pipe_skid_reg_if #(.WIDTH(32)) bus ();

  pipe_skid_reg #(
    .WIDTH       (32),
    .RESET_VALUE (RST_V),
    .NOP_VALUE   (NOP_V)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en   = 1'b0;
  logic [31:0] q[$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the reference queue at the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    logic inf;
    logic outf;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = rdy;
    flush_i         = fl;
    inf  = v && (q.size() < 2);
    outf = rdy && (q.size() > 0);
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(d);
    end
    #1;
  endtask

  // Per-cycle comparison against the reference queue.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("out_valid", {31'd0, bus.out_valid_o}, {31'd0, (q.size() > 0)});
      check("in_ready", {31'd0, bus.in_ready_o}, {31'd0, (q.size() < 2)});
      if (q.size() > 0) check("out_data", bus.out_data_o, q[0]);
    end
  end

  initial begin
    rst_i           = 1'b0;
    flush_i         = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 32'd0;
    bus.out_ready_i = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check("rst_out_data", bus.out_data_o, RST_V);
`ifdef PIPE_SKID_STATS_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_en = 1'b1;

    // Streaming with downstream always ready: 1-cycle latency, full rate.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h11 + k, 1'b1, 1'b0);
      check("stream_data", bus.out_data_o, 32'h11 + k);
      check("stream_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("stream_drained", {31'd0, bus.out_valid_o}, 32'd0);

    // Backpressure into the skid entry, then release.
    drive(1'b1, 32'hA0, 1'b1, 1'b0);
    check("bp_first", bus.out_data_o, 32'hA0);
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    check("bp_skid_ready", {31'd0, bus.in_ready_o}, 32'd0);
    drive(1'b1, 32'hA2, 1'b0, 1'b0);
    check("bp_hold_data", bus.out_data_o, 32'hA0);
    check("bp_hold_ready", {31'd0, bus.in_ready_o}, 32'd0);
    drive(1'b1, 32'hA2, 1'b1, 1'b0);
    check("bp_emit_a1", bus.out_data_o, 32'hA1);
    drive(1'b1, 32'hA2, 1'b1, 1'b0);
    check("bp_emit_a2", bus.out_data_o, 32'hA2);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    check("bp_empty", {31'd0, bus.out_valid_o}, 32'd0);

    // Flush while both entries are held.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    check("fl_pre_ready", {31'd0, bus.in_ready_o}, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    check("fl_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("fl_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check("fl_data", bus.out_data_o, NOP_V);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("fl_no_emit", {31'd0, bus.out_valid_o}, 32'd0);
    end
    // A word accepted in the flush cycle is discarded.
    drive(1'b1, 32'h77, 1'b1, 1'b1);
    check("fl_discard", {31'd0, bus.out_valid_o}, 32'd0);
    drive(1'b1, 32'h88, 1'b1, 1'b0);
    check("fl_restart", bus.out_data_o, 32'h88);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 10000; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset mid-cycle while holding a word.
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    check("ar_pre_valid", {31'd0, bus.out_valid_o}, 32'd1);
    chk_en = 1'b0;
    #3;
    bus.in_valid_i = 1'b0;
    rst_i = 1'b0;
    #2;
    check("ar_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("ar_data", bus.out_data_o, RST_V);
    check("ar_ready", {31'd0, bus.in_ready_o}, 32'd1);
    q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_en = 1'b1;

`ifdef PIPE_SKID_STATS_EN
    check("st_zero", stall_cnt, 32'd0);
    drive(1'b1, 32'h5A, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("st_seven", stall_cnt, 32'd7);
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    check("st_after_flush", stall_cnt, 32'd7);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("st_idle", stall_cnt, 32'd7);
`endif

    drive(1'b1, 32'hAB, 1'b1, 1'b0);
    check("ar_restart", bus.out_data_o, 32'hAB);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline stage; successor to the plain inter-stage register.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and synchronous flush that inserts a bubble.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying a packed stage bundle.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VALUE, 0, value of the main and skid data registers on reset.
- NOP_VALUE, 0, value loaded into both data registers on flush (bubble payload).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discard all held entries.
- in_valid_i  in  1  upstream presents data.
- in_ready_o  out  1  stage can accept; driven directly from a flop (= !skid_valid).
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  main entry valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  WIDTH  main register payload.
- stall_cnt_o  out  32  only with PIPE_SKID_STATS_EN.

Behaviour:
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- States, encoded from (main_valid, skid_valid):
  - EMPTY = (0,0).
  - FULL = (1,0).
  - SKID = (1,1).
- Reset (rst_i=0, asynchronous):
  - state EMPTY; out_valid_o=0; in_ready_o=1.
  - out_data_o and skid register = RESET_VALUE.
  - stall_cnt_o=0.
- Transitions, evaluated in priority order:
  - flush_i=1 has top priority. Next state is EMPTY and both data registers load NOP_VALUE.
    - An in_fire in the flush cycle is accepted and discarded.
    - An out_fire in the flush cycle is a valid transfer; downstream takes the current out_data_o.
  - EMPTY:
    - in_fire → FULL, main<=in_data_i.
  - FULL:
    - in_fire & out_fire → FULL, main<=in_data_i.
    - in_fire & !out_fire → SKID, skid<=in_data_i.
    - !in_fire & out_fire → EMPTY.
    - Neither → hold.
  - SKID (in_ready_o=0):
    - out_fire → FULL, main<=skid.
    - Otherwise hold.
- Latency and throughput:
  - Latency in→out is 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready_i=1.
- Ordering and stability:
  - Words leave in the order they were accepted; none are dropped or duplicated except by flush.
  - While out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change (unless flush).
- No combinational path from any input to in_ready_o.
- out_valid_o and out_data_o are registered.
- Deasserting rst_i mid-stream: the stage restarts in EMPTY; prior contents are lost.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined:
  - stall_cnt_o counts cycles with out_valid_o=1 & out_ready_i=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst_i; flush does not clear it.
- Undefined: port stall_cnt_o and its counter are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - state localparams EMPTY=2'b00, FULL=2'b10, SKID=2'b11 (main_valid, skid_valid).
  - STALL_CNT_W=32.
- One natural sub-module: pipe_sat_cnt (saturating enable counter), instantiated only under PIPE_SKID_STATS_EN.

Test Plan:
- Reset, then stream 0x11..0x18 with out_ready_i=1 → outputs 0x11..0x18, one per cycle, 1-cycle latency, in_ready_o constantly 1.
- Stream 0xA0,0xA1,0xA2 with out_ready_i=0 from the 2nd cycle:
  - state reaches SKID; in_ready_o=0; out_data_o holds 0xA0.
  - Then raise out_ready_i → 0xA0, 0xA1 emitted, then 0xA2.
- SKID state holding 0x55 (main) and 0x66 (skid), assert flush_i for 1 cycle:
  - next cycle out_valid_o=0, in_ready_o=1, out_data_o=NOP_VALUE.
  - Neither 0x55 nor 0x66 emitted afterwards.
- Random in_valid_i/out_ready_i (50% each) for 10 000 cycles → scoreboard: output sequence equals accepted-input sequence; no change of out_data_o while stalled.
- Assert rst_i=0 asynchronously mid-cycle while FULL → out_valid_o=0 immediately, out_data_o=RESET_VALUE, before the next clock edge.
- With PIPE_SKID_STATS_EN: hold out_ready_i=0 with valid data for 7 cycles → stall_cnt_o=7; a flush leaves it at 7.
